// File: rtl/stack_sched_pkg.sv
// Shared definitions for the two-requester stack scheduler: op encodings,
// FSM states, default geometry and the round-robin pick helper.
package stack_sched_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_EXCH = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Returns the winning requester id; prio names the requester favoured on a tie.
    function automatic logic rr_pick(input logic req_a, input logic req_b, input logic prio);
        logic win;
        if (req_a && req_b) begin
            win = prio;
        end else if (req_b) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/stack_sched_core.sv
// stack_core: DEPTH x WIDTH LIFO storage with entry counter, one command per cycle.
// Optional peek support is enabled by defining STACK_SCHED_PEEK_EN.
module stack_core
    import stack_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_vld,
    input  logic [1:0]               i_op,
    input  logic [WIDTH-1:0]         i_din,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_res_err,
    output logic [WIDTH-1:0]         o_res_dout,
    output logic                     o_ovf_evt,
    output logic                     o_unf_evt,
    output logic                     o_push_ok,
    output logic                     o_pop_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_TWO  = AW'(2);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_depth;

    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic [AW:0]      w_depth_nxt;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_sec_idx;
    logic             w_err;
    logic [WIDTH-1:0] w_dout;
    logic             w_ovf;
    logic             w_unf;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Index arithmetic wraps modulo DEPTH, so a full stack still yields the correct top index.
    assign w_wr_idx  = r_depth[AW-1:0];
    assign w_top_idx = w_wr_idx - IDX_ONE;
    assign w_sec_idx = w_wr_idx - IDX_TWO;

    // Next stack contents and result for the presented command.
    always_comb begin
        w_mem_nxt   = r_mem;
        w_depth_nxt = r_depth;
        w_err       = 1'b0;
        w_dout      = {WIDTH{1'b0}};
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_push_ok   = 1'b0;
        w_pop_ok    = 1'b0;
        case (i_op)
            OP_PUSH: begin
                if (r_depth == CNT_FULL) begin
                    w_err = 1'b1;
                    w_ovf = 1'b1;
                end else begin
                    w_mem_nxt[w_wr_idx] = i_din;
                    w_depth_nxt         = r_depth + CNT_ONE;
                    w_push_ok           = 1'b1;
                end
            end
            OP_POP: begin
                if (r_depth == {(AW+1){1'b0}}) begin
                    w_err = 1'b1;
                    w_unf = 1'b1;
                end else begin
                    w_dout               = r_mem[w_top_idx];
                    w_mem_nxt[w_top_idx] = {WIDTH{1'b0}};
                    w_depth_nxt          = r_depth - CNT_ONE;
                    w_pop_ok             = 1'b1;
                end
            end
            OP_EXCH: begin
                if (r_depth < CNT_TWO) begin
                    w_err = 1'b1;
                end else begin
                    w_mem_nxt[w_top_idx] = r_mem[w_sec_idx];
                    w_mem_nxt[w_sec_idx] = r_mem[w_top_idx];
                    w_dout               = r_mem[w_sec_idx];
                end
            end
            OP_PEEK: begin
`ifdef STACK_SCHED_PEEK_EN
                if (r_depth == {(AW+1){1'b0}}) begin
                    w_err = 1'b1;
                    w_unf = 1'b1;
                end else begin
                    w_dout = r_mem[w_top_idx];
                end
`else
                w_err = 1'b1;
`endif
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Storage and counter; only a valid command commits its next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem   <= '{default: {WIDTH{1'b0}}};
            r_depth <= {(AW+1){1'b0}};
        end else if (i_cmd_vld) begin
            r_mem   <= w_mem_nxt;
            r_depth <= w_depth_nxt;
        end
    end

    assign o_depth    = r_depth;
    assign o_res_err  = w_err;
    assign o_res_dout = w_dout;
    assign o_ovf_evt  = w_ovf;
    assign o_unf_evt  = w_unf;
    assign o_push_ok  = w_push_ok;
    assign o_pop_ok   = w_pop_ok;

endmodule

// File: rtl/stack_sched.sv
// stack_sched: round-robin arbiter and IDLE/EXEC/RESP sequencer in front of stack_core.
// Define STACK_SCHED_PEEK_EN to make op 11 a non-destructive read of the top entry.
module stack_sched
    import stack_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   ctl,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [1:0]             op0,
    input  logic [1:0]             op1,
    input  logic [WIDTH-1:0]       din0,
    input  logic [WIDTH-1:0]       din1,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   err0,
    output logic                   err1,
    output logic [WIDTH-1:0]       dout0,
    output logic [WIDTH-1:0]       dout1,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   over,
    output logic                   under
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_grant;
    logic             w_exec;
    logic             w_resp;
    logic             w_win;

    logic             r_prio;
    logic             r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_din;
    logic             r_res_err;
    logic [WIDTH-1:0] r_res_dout;
    logic             r_over;
    logic             r_under;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err0;
    logic             r_err1;
    logic [WIDTH-1:0] r_dout0;
    logic [WIDTH-1:0] r_dout1;

    logic             w_res_err;
    logic [WIDTH-1:0] w_res_dout;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_win = rr_pick(req0, req1, r_prio);

    // FSM state register.
    always_ff @(posedge ctl) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-phase strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_exec      = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = EXEC;
                    w_grant     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
                w_exec      = 1'b1;
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_resp      = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, result/flag capture and the one-cycle response pulse.
    always_ff @(posedge ctl) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_id       <= 1'b0;
            r_op       <= 2'b00;
            r_din      <= {WIDTH{1'b0}};
            r_res_err  <= 1'b0;
            r_res_dout <= {WIDTH{1'b0}};
            r_over     <= 1'b0;
            r_under    <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_dout0    <= {WIDTH{1'b0}};
            r_dout1    <= {WIDTH{1'b0}};
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_dout0 <= {WIDTH{1'b0}};
            r_dout1 <= {WIDTH{1'b0}};
            if (w_grant) begin
                r_id   <= w_win;
                r_op   <= w_win ? op1 : op0;
                r_din  <= w_win ? din1 : din0;
                r_prio <= ~w_win;
            end
            if (w_exec) begin
                r_res_err  <= w_res_err;
                r_res_dout <= w_res_dout;
                // Sticky flags: set by the failing op, cleared by the opposite successful op.
                if (w_ovf_evt) begin
                    r_over <= 1'b1;
                end else if (w_pop_ok) begin
                    r_over <= 1'b0;
                end
                if (w_unf_evt) begin
                    r_under <= 1'b1;
                end else if (w_push_ok) begin
                    r_under <= 1'b0;
                end
            end
            if (w_resp) begin
                r_ack0  <= ~r_id;
                r_ack1  <= r_id;
                r_err0  <= ~r_id & r_res_err;
                r_err1  <= r_id & r_res_err;
                r_dout0 <= r_id ? {WIDTH{1'b0}} : r_res_dout;
                r_dout1 <= r_id ? r_res_dout : {WIDTH{1'b0}};
            end
        end
    end

    stack_core #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk      (ctl),
        .i_rst      (rst),
        .i_cmd_vld  (w_exec),
        .i_op       (r_op),
        .i_din      (r_din),
        .o_depth    (depth),
        .o_res_err  (w_res_err),
        .o_res_dout (w_res_dout),
        .o_ovf_evt  (w_ovf_evt),
        .o_unf_evt  (w_unf_evt),
        .o_push_ok  (w_push_ok),
        .o_pop_ok   (w_pop_ok)
    );

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign err0  = r_err0;
    assign err1  = r_err1;
    assign dout0 = r_dout0;
    assign dout1 = r_dout1;
    assign over  = r_over;
    assign under = r_under;

endmodule

// File: tb/tb_stack_sched.sv
// Scoreboard bench for stack_sched: a queue-based LIFO reference model predicts every
// ack (requester, err, dout, depth, flags); a negedge monitor compares. Honors STACK_SCHED_PEEK_EN.
module tb_stack_sched;
    import stack_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic             ctl = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [1:0]       op0 = 2'b00;
    logic [1:0]       op1 = 2'b00;
    logic [WIDTH-1:0] din0 = '0;
    logic [WIDTH-1:0] din1 = '0;
    logic             ack0, ack1, err0, err1, over, under;
    logic [WIDTH-1:0] dout0, dout1;
    logic [2:0]       depth;

    always #5 ctl = ~ctl;

    stack_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .ctl(ctl), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .dout0(dout0), .dout1(dout1), .depth(depth), .over(over), .under(under)
    );

    typedef struct {
        int               id;
        logic             err;
        logic [WIDTH-1:0] dout;
        int               dep;
        logic             ov;
        logic             un;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_over  = 1'b0;
    logic             m_under = 1'b0;
    int               m_prio  = 0;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: applies one operation in arbitration order and queues the expected ack.
    function automatic void model_op(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
        exp_t e;
        logic [WIDTH-1:0] tmp;
        e.id = id; e.err = 1'b0; e.dout = '0;
        if (op == OP_PUSH) begin
            if (m_stk.size() == DEPTH) begin e.err = 1'b1; m_over = 1'b1; end
            else begin m_stk.push_back(d); m_under = 1'b0; end
        end else if (op == OP_POP) begin
            if (m_stk.size() == 0) begin e.err = 1'b1; m_under = 1'b1; end
            else begin e.dout = m_stk.pop_back(); m_over = 1'b0; end
        end else if (op == OP_EXCH) begin
            if (m_stk.size() < 2) e.err = 1'b1;
            else begin
                tmp = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = m_stk[m_stk.size()-2];
                m_stk[m_stk.size()-2] = tmp;
                e.dout = m_stk[m_stk.size()-1];
            end
        end else begin
`ifdef STACK_SCHED_PEEK_EN
            if (m_stk.size() == 0) begin e.err = 1'b1; m_under = 1'b1; end
            else e.dout = m_stk[m_stk.size()-1];
`else
            e.err = 1'b1;
`endif
        end
        e.dep = m_stk.size(); e.ov = m_over; e.un = m_under;
        exp_q.push_back(e);
    endfunction

    // Monitor: every ack is matched against the head of the scoreboard; idle cycles must be quiet.
    always @(negedge ctl) begin
        if (!rst) begin
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected no ack (t=%0t)", ack0, ack1, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_pair", {ack0, ack1}, (mon_e.id == 1) ? 32'd1 : 32'd2);
                    check("err", (mon_e.id == 1) ? err1 : err0, mon_e.err);
                    check("dout", (mon_e.id == 1) ? dout1 : dout0, mon_e.dout);
                    check("other_quiet", (mon_e.id == 1) ? {err0, dout0} : {err1, dout1}, 32'd0);
                    check("depth", depth, mon_e.dep);
                    check("over", over, mon_e.ov);
                    check("under", under, mon_e.un);
                end
            end else begin
                check("idle_zero", {err0, err1, dout0, dout1}, 32'd0);
            end
        end
    end

    // One arbitration round: predict order, raise requests, drop each on its ack, check latency.
    task automatic do_round(input bit u0, input bit u1,
                            input logic [1:0] o0, input logic [WIDTH-1:0] d0,
                            input logic [1:0] o1, input logic [WIDTH-1:0] d1);
        int first, last, cnt, nack;
        bit p0, p1;
        first = (u0 && u1) ? m_prio : (u0 ? 0 : 1);
        if (first == 0) begin
            if (u0) model_op(0, o0, d0);
            if (u1) model_op(1, o1, d1);
        end else begin
            if (u1) model_op(1, o1, d1);
            if (u0) model_op(0, o0, d0);
        end
        last   = (u0 && u1) ? 1 - first : first;
        m_prio = 1 - last;
        req0 = u0; op0 = o0; din0 = d0;
        req1 = u1; op1 = o1; din1 = d1;
        p0 = u0; p1 = u1; cnt = 0; nack = 0;
        while (p0 || p1) begin
            @(negedge ctl);
            cnt++;
            if (p0 && ack0) begin nack++; check("latency0", cnt, 3 * nack); req0 = 1'b0; p0 = 1'b0; end
            if (p1 && ack1) begin nack++; check("latency1", cnt, 3 * nack); req1 = 1'b0; p1 = 1'b0; end
            if (cnt > 12 && (p0 || p1)) begin
                n_checks++; n_fail++;
                $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack within 6", cnt);
                req0 = 1'b0; req1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
            end
        end
        @(negedge ctl);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge ctl);
        rst = 1'b0;
        m_stk.delete(); m_over = 1'b0; m_under = 1'b0; m_prio = 0;
        @(negedge ctl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge ctl);
        do_reset();
        check("rst_depth", depth, 32'd0);
        check("rst_flags", {over, under, ack0, ack1}, 32'd0);

        // Basic push/push/pop.
        do_round(1, 0, OP_PUSH, 4'h5, OP_PUSH, 4'h0);
        do_round(1, 0, OP_PUSH, 4'hA, OP_PUSH, 4'h0);
        do_round(1, 0, OP_POP, 4'h0, OP_PUSH, 4'h0);

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        do_round(1, 1, OP_PUSH, 4'h3, OP_PUSH, 4'hC);
        do_round(0, 1, OP_POP, 4'h0, OP_POP, 4'h0);

        // Overflow then recovery.
        do_reset();
        for (int i = 0; i < 4; i++) do_round(1, 0, OP_PUSH, 4'(i + 1), OP_PUSH, 4'h0);
        do_round(1, 0, OP_PUSH, 4'hF, OP_PUSH, 4'h0);
        do_round(0, 1, OP_POP, 4'h0, OP_POP, 4'h0);

        // Underflow then recovery.
        do_reset();
        do_round(1, 0, OP_POP, 4'h0, OP_PUSH, 4'h0);
        do_round(0, 1, OP_PUSH, 4'h0, OP_PUSH, 4'h7);

        // Exchange behaviour.
        do_reset();
        do_round(1, 0, OP_PUSH, 4'h1, OP_PUSH, 4'h0);
        do_round(1, 0, OP_PUSH, 4'h2, OP_PUSH, 4'h0);
        do_round(1, 0, OP_EXCH, 4'h0, OP_PUSH, 4'h0);
        do_round(1, 0, OP_POP, 4'h0, OP_PUSH, 4'h0);
        do_round(1, 0, OP_POP, 4'h0, OP_PUSH, 4'h0);
        do_round(1, 0, OP_PUSH, 4'h6, OP_PUSH, 4'h0);
        do_round(1, 0, OP_EXCH, 4'h0, OP_PUSH, 4'h0);

        // Reset during EXEC of a push aborts it without an ack.
        do_reset();
        req0 = 1'b1; op0 = OP_PUSH; din0 = 4'h5;
        @(negedge ctl);
        rst = 1'b1; req0 = 1'b0;
        repeat (2) @(negedge ctl);
        rst = 1'b0;
        m_stk.delete(); m_over = 1'b0; m_under = 1'b0; m_prio = 0;
        repeat (5) @(negedge ctl);
        check("abort_depth", depth, 32'd0);

        // Peek at depth 1.
        do_round(1, 0, OP_PUSH, 4'h9, OP_PUSH, 4'h0);
        do_round(0, 1, OP_PUSH, 4'h0, OP_PEEK, 4'h0);

        // Randomized traffic.
        for (int r = 0; r < 200; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            do_round(mode != 1, mode != 0,
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        repeat (4) @(negedge ctl);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_sched.md
STACK_SCHED -- requirements
Module: stack_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of stack entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 4, bits per stack entry.
REQ-003 SHALL have port ctl, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1, requester n asks for a stack operation.
REQ-006 SHALL have ports op0/op1, input, 2, operation: 00 push, 01 pop, 10 exchange top two, 11 peek.
REQ-007 SHALL have ports din0/din1, input, WIDTH, push data.
REQ-008 SHALL have ports ack0/ack1, output, 1, one-cycle completion pulse to requester n.
REQ-009 SHALL have ports err0/err1, output, 1, qualifies ack: operation rejected.
REQ-010 SHALL have ports dout0/dout1, output, WIDTH, pop/peek result, valid with ack.
REQ-011 SHALL have port depth, output, log2(DEPTH)+1, current entry count.
REQ-012 SHALL have ports over/under, output, 1 each, sticky overflow/underflow flags.

Function
REQ-013 SHALL use FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 In IDLE with any req high, SHALL latch the winner's id, op and din and go to EXEC; otherwise stay IDLE.
REQ-015 Arbitration SHALL be round-robin: one requester -> it wins; both -> the one not granted last; pointer after reset favours requester 0.
REQ-016 EXEC SHALL perform the operation on the stack in one cycle, then go to RESP.
REQ-017 RESP SHALL pulse ack of the granted requester for exactly one cycle, with err/dout valid in that cycle, then return to IDLE.
REQ-018 Latency: req sampled high in IDLE at edge N -> ack high in the cycle after edge N+2.
REQ-019 Requester SHALL hold req/op/din stable until ack; req still high in the IDLE cycle after ack is a new request.
REQ-020 Push SHALL write din at index depth and increment depth; pop SHALL return top, zero the vacated entry, decrement depth.
REQ-021 Exchange SHALL swap entries depth-1 and depth-2, depth unchanged, dout = new top.
REQ-022 Push at depth==DEPTH SHALL leave stack unchanged, set err and over.
REQ-023 Pop or peek at depth==0 SHALL leave stack unchanged, return dout 0, set err and under.
REQ-024 Exchange at depth<2 SHALL leave stack unchanged and set err; flags unchanged.
REQ-025 over SHALL clear on the next successful pop; under SHALL clear on the next successful push.
REQ-026 ack, err, dout SHALL be 0 whenever no ack is issued.

Reset
REQ-027 rst high at an edge SHALL force IDLE, depth 0, all entries 0, ack/err/dout/over/under 0, pointer favouring requester 0.
REQ-028 rst during EXEC or RESP SHALL abort the operation with no ack issued and no stack change surviving.

Configuration
REQ-029 With STACK_SCHED_PEEK_EN defined, op 11 SHALL return top in dout without changing the stack.
REQ-030 Without STACK_SCHED_PEEK_EN, op 11 SHALL be acked with err=1, dout 0, stack and flags unchanged.

Structure
REQ-031 A shared package SHALL hold the op encodings (OP_PUSH, OP_POP, OP_EXCH, OP_PEEK), the FSM state typedef and default DEPTH/WIDTH.
REQ-032 Storage SHALL be a sub-module stack_core (DEPTH x WIDTH registers plus depth counter, one command per cycle); stack_sched holds arbiter and FSM.

Verification
REQ-033 Reset, req0 push 0x5, push 0xA -> each ack0 at N+3, depth 2; pop -> dout0 0xA, depth 1.
REQ-034 req0 and req1 high together, both op push (0x3, 0xC) -> req0 acked first, req1 acked 3 cycles later; top 0xC.
REQ-035 Four pushes then push 0xF -> ack err=1, over=1, depth 4; one pop -> over=0, dout 0xF absent (top is 4th value).
REQ-036 Empty stack pop -> ack err=1, dout 0, under=1; then push 0x7 -> under=0, depth 1.
REQ-037 Push 0x1, 0x2, exch -> dout 0x1; pop twice -> 0x1 then 0x2; exch at depth 1 -> err=1.
REQ-038 rst asserted in EXEC of a push -> no ack, depth 0; op 11 at depth 1 -> dout top, err 0 with STACK_SCHED_PEEK_EN, err 1 without.
